aftab_seq_divider: RTL and testbench
====================================

// Module: aftab_seq_divider
// PURPOSE
//  Iterative restoring divider for the AFTAB M-extension path (DIV/DIVU/REM/REMU).
//  Takes operand magnitudes from two's-complement conversion and runs one quotient
//  bit per cycle. It then applies sign fix-up to the quotient and remainder.
//  Sits between the register-read operand muxes and the writeback mux; the
//  controller handshakes with it via start/busy/done.
// PARAMETERS
//  WIDTH  32  operand / quotient / remainder width in bits
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      synchronous, active-high reset
//  start        in   1      request; sampled only in IDLE
//  signed_op    in   1      1 = DIV/REM semantics, 0 = DIVU/REMU
//  dividend     in   WIDTH  dividend, sampled on the accepted start edge
//  divisor      in   WIDTH  divisor, sampled on the accepted start edge
//  busy         out  1      high from the cycle after an accepted start until done
//  done         out  1      one-cycle pulse; quotient/remainder valid in that cycle
//  quotient     out  WIDTH  result, held until the next accepted start
//  remainder    out  WIDTH  result, held until the next accepted start
//  div_by_zero  out  1      flag for divisor==0, valid with done, held like results
// BEHAVIOUR
//  Reset (synchronous, wins over everything): state=IDLE; busy, done, div_by_zero,
//   quotient, remainder = 0. A reset mid-operation aborts the operation and no done is produced.
//  FSM: IDLE -> PREP -> ITER (WIDTH cycles, counter 0..WIDTH-1) -> FIX -> IDLE.
//  IDLE: start=1 registers operands and signed_op, then goes to PREP. A start while busy is ignored.
//  PREP: sign flags sd=dividend[MSB]&signed_op, sv=divisor[MSB]&signed_op.
//   Magnitudes are |x| = sign ? (~x+1) : x, computed in WIDTH bits.
//   For x = -2^(WIDTH-1), the magnitude 2^(WIDTH-1) is a correct unsigned value.
//   Clear the partial remainder (WIDTH+1 bits). Clear the counter.
//  ITER: rem = {rem[WIDTH-1:0], q[MSB]}; q <<= 1. trial = rem - {0,|divisor|}.
//   If trial >= 0, then rem=trial and q[0]=1; otherwise restore and q[0]=0.
//   After count WIDTH-1, go to FIX.
//  FIX: quotient = (sd^sv && divisor!=0) ? -q : q; remainder = sd ? -rem : rem.
//   Outputs are registered. done=1 for this single edge's following cycle; busy drops with it.
//  Latency: done is high WIDTH+2 edges after the start edge (34 for WIDTH=32).
//   A new start is accepted in the cycle done is high (state is IDLE).
//  Divide by zero (no fast path): the unsigned iteration yields q=all-ones and rem=|dividend|.
//   Fix-up gives quotient=all-ones and remainder=dividend (RISC-V spec). div_by_zero=1.
//  Overflow (signed -2^(WIDTH-1) / -1): quotient=0x80000000, remainder=0, no flag.
//  All arithmetic is modulo 2^WIDTH. No exceptions are raised.
// CONFIGURATION
//  AFTAB_DIV_ZERO_FASTPATH_EN defined: if PREP sees divisor==0, it skips ITER and goes straight to FIX.
//   FIX forces q=all-ones and rem=|dividend|, so done comes 2 edges after start. Results are identical.
//  Undefined: divide-by-zero takes the full WIDTH+2 latency.
// STRUCTURE
//  Shared package aftab_div_pkg holds:
//   - state encoding localparams: S_IDLE=0, S_PREP=1, S_ITER=2, S_FIX=3
//   - the counter-width function clog2(WIDTH)
//  Sub-module aftab_div_step: one combinational restoring step.
//   Inputs: rem, q, |divisor|. Outputs: next rem, next q.
//  The top level holds the FSM, counter, operand registers and sign fix-up.
// TESTING
//  1. DIVU 100/7: start with signed_op=0 -> done at edge 34; q=14, r=2, div_by_zero=0.
//  2. DIV -7/2 -> q=0xFFFFFFFD (-3), r=0xFFFFFFFF (-1); DIV 7/-2 -> q=-3, r=1.
//  3. DIV 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0; DIVU same operands -> q=0, r=0x80000000.
//  4. DIV -5/0 -> q=0xFFFFFFFF, r=0xFFFFFFFB, div_by_zero=1.
//     Latency is 34 edges without the macro and 2 with AFTAB_DIV_ZERO_FASTPATH_EN.
//  5. Hold start=1 with new operands during busy -> ignored. Outputs change only at done.
//     Back-to-back start in the done cycle is accepted.
//  6. Assert rst at ITER count 10 -> next cycle: busy=0, done=0, outputs=0, and no done pulse follows.
//     The next start completes normally.

Source files
------------

// File: rtl/aftab_div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aftab_div_pkg
//  Description : Shared definitions for the AFTAB sequential divider.
//                - divider FSM state encoding (2-bit localparams)
//                - clog2() helper used to size the iteration counter
//  Revision    : 1.0 - initial release
// ============================================================================
package aftab_div_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PREP = 2'd1;
    localparam logic [1:0] S_ITER = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    // Bits needed to count 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aftab_div_step.sv
`default_nettype none
// ============================================================================
//  Module      : aftab_div_step
//  Description : One combinational restoring-division step.
//                Shifts the next dividend bit (MSB of i_q) into the partial
//                remainder, trial-subtracts the divisor magnitude and either
//                keeps the difference (quotient bit 1) or restores (bit 0).
//  Ports       : i_rem     partial remainder in
//                i_q       dividend/quotient shift register in
//                i_dvs_mag divisor magnitude
//                o_rem     partial remainder out
//                o_q       quotient shift register out
//  Revision    : 1.0 - initial release
// ============================================================================
module aftab_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_dvs_mag,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_trial;

    // The partial remainder is always below the divisor magnitude, so its
    // (WIDTH+1)-bit form has a zero top bit and only WIDTH bits are carried.
    // The shifted value and the trial difference need the full WIDTH+1 bits;
    // w_trial[WIDTH] is the sign of the trial subtraction.
    always_comb begin
        w_shift = {i_rem, i_q[WIDTH-1]};
        w_trial = w_shift - {1'b0, i_dvs_mag};
        o_rem   = w_shift[WIDTH-1:0];
        o_q     = {i_q[WIDTH-2:0], 1'b0};
        if (!w_trial[WIDTH]) begin
            o_rem = w_trial[WIDTH-1:0];
            o_q   = {i_q[WIDTH-2:0], 1'b1};
        end
    end

endmodule
`default_nettype wire

// File: rtl/aftab_seq_divider.sv
`default_nettype none
// ============================================================================
//  Module      : aftab_seq_divider
//  Description : Iterative restoring divider for DIV/DIVU/REM/REMU.
//                IDLE -> PREP -> ITER (WIDTH cycles) -> FIX -> IDLE.
//                Operands are converted to magnitudes in PREP, one quotient
//                bit is produced per ITER cycle, and FIX applies the sign
//                fix-up and registers the results with a one-cycle done.
//  Ports       : clk, rst (sync, active-high)
//                start, signed_op, dividend, divisor  - request
//                busy, done                           - handshake
//                quotient, remainder, div_by_zero     - held results
//  Options     : AFTAB_DIV_ZERO_FASTPATH_EN - a zero divisor skips ITER,
//                giving done 2 edges after start with identical results.
//  Revision    : 1.0 - initial release
// ============================================================================
module aftab_seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    import aftab_div_pkg::*;

    localparam int               c_cnt_w = clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_dvd;
    logic [WIDTH-1:0]   r_dvs;
    logic               r_signed;
    logic               r_sd;
    logic               r_sv;
    logic [WIDTH-1:0]   r_dvs_mag;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_rem;

    logic               w_sd;
    logic               w_sv;
    logic [WIDTH-1:0]   w_dvd_mag;
    logic [WIDTH-1:0]   w_dvs_mag;
    logic [WIDTH-1:0]   w_step_rem;
    logic [WIDTH-1:0]   w_step_q;
    logic               w_dvs_zero;

    // Magnitudes: -2^(WIDTH-1) negates to itself, which read as unsigned
    // is exactly the magnitude 2^(WIDTH-1).
    assign w_sd       = r_dvd[WIDTH-1] & r_signed;
    assign w_sv       = r_dvs[WIDTH-1] & r_signed;
    assign w_dvd_mag  = w_sd ? (~r_dvd + 1'b1) : r_dvd;
    assign w_dvs_mag  = w_sv ? (~r_dvs + 1'b1) : r_dvs;
    assign w_dvs_zero = (r_dvs == '0);

    assign busy = (r_state != S_IDLE);

    aftab_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_rem     (r_rem),
        .i_q       (r_q),
        .i_dvs_mag (r_dvs_mag),
        .o_rem     (w_step_rem),
        .o_q       (w_step_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_PREP;
                end
            end
            S_PREP: begin
`ifdef AFTAB_DIV_ZERO_FASTPATH_EN
                w_next_state = w_dvs_zero ? S_FIX : S_ITER;
`else
                w_next_state = S_ITER;
`endif
            end
            S_ITER: begin
                if (r_cnt == c_last) begin
                    w_next_state = S_FIX;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            r_cnt       <= '0;
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_signed    <= 1'b0;
            r_sd        <= 1'b0;
            r_sv        <= 1'b0;
            r_dvs_mag   <= '0;
            r_q         <= '0;
            r_rem       <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_dvd    <= dividend;
                        r_dvs    <= divisor;
                        r_signed <= signed_op;
                    end
                end
                S_PREP: begin
                    r_sd      <= w_sd;
                    r_sv      <= w_sv;
                    r_dvs_mag <= w_dvs_mag;
                    r_q       <= w_dvd_mag;   // dividend bits shift out as quotient bits shift in
                    r_rem     <= '0;
                    r_cnt     <= '0;
`ifdef AFTAB_DIV_ZERO_FASTPATH_EN
                    // Same values the full iteration would leave for a zero divisor.
                    if (w_dvs_zero) begin
                        r_q   <= '1;
                        r_rem <= w_dvd_mag;
                    end
`endif
                end
                S_ITER: begin
                    r_rem <= w_step_rem;
                    r_q   <= w_step_q;
                    r_cnt <= r_cnt + 1'b1;
                end
                default: begin
                    // A zero divisor keeps the all-ones quotient unsigned-style,
                    // and the remainder fix-up returns the original dividend.
                    quotient    <= ((r_sd ^ r_sv) && !w_dvs_zero) ? (~r_q + 1'b1) : r_q;
                    remainder   <= r_sd ? (~r_rem + 1'b1) : r_rem;
                    div_by_zero <= w_dvs_zero;
                    done        <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aftab_seq_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aftab_seq_divider
//  Description : Self-checking bench for aftab_seq_divider (WIDTH=32).
//                Directed cases with constant expectations, randomized
//                operations against an arithmetic reference model, start
//                ignored while busy, back-to-back starts and mid-op reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aftab_seq_divider;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         signed_op;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int total = 0;
    int bad   = 0;

    aftab_seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_op   (signed_op),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // RISC-V M-extension division semantics in plain arithmetic.
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input bit s, output logic [W-1:0] q,
                                    output logic [W-1:0] r, output bit z);
        z = (b == 0);
        if (b == 0) begin
            q = '1;
            r = a;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 0;
        end else if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    function automatic int exp_lat(input logic [W-1:0] b);
`ifdef AFTAB_DIV_ZERO_FASTPATH_EN
        return (b == 0) ? 2 : W + 2;
`else
        return (b == 0) ? W + 2 : W + 2;
`endif
    endfunction

    // Issues one request starting now (caller sits #1 after a rising edge)
    // and returns the number of edges from the start edge until done.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                          output int lat, output bit timed_out);
        dividend  = a;
        divisor   = b;
        signed_op = s;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!done && lat < 60);
        timed_out = !done;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; signed_op = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({busy, done, div_by_zero} !== 3'b000 || quotient !== '0 || remainder !== '0) begin
            bad++;
            $display("FAIL reset_state: busy=%b done=%b dbz=%b q=%h r=%h, want all zero",
                     busy, done, div_by_zero, quotient, remainder);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        bit           s;
        logic [W-1:0] eq;
        logic [W-1:0] er;
        bit           ez;
    } dir_t;

    task automatic test_directed();
        dir_t tbl[6];
        int   lat;
        bit   to;
        tbl[0] = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0};
        tbl[1] = '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
        tbl[2] = '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          1'b0};
        tbl[3] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1'b0};
        tbl[4] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000,  1'b0};
        tbl[5] = '{32'hFFFF_FFFB,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFB,  1'b1};
        for (int i = 0; i < 6; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].s, lat, to);
            total++;
            if (to || lat != exp_lat(tbl[i].b)) begin
                bad++;
                $display("FAIL dir%0d_latency: got %0d edges (timeout=%b), want %0d", i, lat, to, exp_lat(tbl[i].b));
            end
            total++;
            if (quotient !== tbl[i].eq || remainder !== tbl[i].er || div_by_zero !== tbl[i].ez) begin
                bad++;
                $display("FAIL dir%0d_result: got q=%h r=%h dbz=%b, want q=%h r=%h dbz=%b",
                         i, quotient, remainder, div_by_zero, tbl[i].eq, tbl[i].er, tbl[i].ez);
            end
            total++;
            if (busy !== 1'b0) begin
                bad++;
                $display("FAIL dir%0d_busy_at_done: got %b want 0", i, busy);
            end
            @(posedge clk); #1;
            total++;
            if (done !== 1'b0) begin
                bad++;
                $display("FAIL dir%0d_done_pulse: done still %b one cycle later, want 0", i, done);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, eq, er;
        bit           s, ez, to;
        int           lat;
        for (int i = 0; i < 30; i++) begin
            a = $urandom;
            b = $urandom;
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: b = 0;
                1: b = '1;
                2: b = $urandom_range(1, 15);
                3: a = 32'h8000_0000;
                default: ;
            endcase
            ref_div(a, b, s, eq, er, ez);
            run_op(a, b, s, lat, to);
            total++;
            if (to || lat != exp_lat(b) || quotient !== eq || remainder !== er || div_by_zero !== ez) begin
                bad++;
                $display("FAIL rand%0d a=%h b=%h s=%b: got q=%h r=%h dbz=%b lat=%0d, want q=%h r=%h dbz=%b lat=%0d",
                         i, a, b, s, quotient, remainder, div_by_zero, lat, eq, er, ez, exp_lat(b));
            end
        end
    endtask

    task automatic test_busy_ignore();
        logic [W-1:0] pq, pr, eq, er;
        bit           ez;
        int           lat;
        pq = quotient;
        pr = remainder;
        ref_div(32'd1000, 32'd3, 1'b1, eq, er, ez);
        dividend = 32'd1000; divisor = 32'd3; signed_op = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        while (!done && lat < 60) begin
            total++;
            if (busy !== 1'b1 || quotient !== pq || remainder !== pr) begin
                bad++;
                $display("FAIL busy_hold cycle%0d: busy=%b q=%h r=%h, want busy=1 q=%h r=%h",
                         lat, busy, quotient, remainder, pq, pr);
            end
            dividend  = $urandom;
            divisor   = $urandom_range(1, 1000);
            signed_op = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        total++;
        if (!done || lat != W + 2 || quotient !== eq || remainder !== er || div_by_zero !== ez) begin
            bad++;
            $display("FAIL busy_ignore_result: done=%b lat=%0d q=%h r=%h, want done=1 lat=%0d q=%h r=%h",
                     done, lat, quotient, remainder, W + 2, eq, er);
        end
        @(posedge clk); #1;
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL busy_ignore_idle: done=%b busy=%b, want 0 0", done, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] eq, er;
        bit           ez, to;
        int           lat;
        run_op(32'd12345, 32'd67, 1'b0, lat, to);
        ref_div(32'd12345, 32'd67, 1'b0, eq, er, ez);
        total++;
        if (to || quotient !== eq || remainder !== er) begin
            bad++;
            $display("FAIL b2b_first: q=%h r=%h timeout=%b, want q=%h r=%h", quotient, remainder, to, eq, er);
        end
        // still in the done cycle: issue the next request right away
        run_op(32'hFFFF_FC18, 32'd9, 1'b1, lat, to);
        ref_div(32'hFFFF_FC18, 32'd9, 1'b1, eq, er, ez);
        total++;
        if (to || lat != W + 2 || quotient !== eq || remainder !== er || div_by_zero !== ez) begin
            bad++;
            $display("FAIL b2b_second: q=%h r=%h lat=%0d, want q=%h r=%h lat=%0d",
                     quotient, remainder, lat, eq, er, W + 2);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] eq, er;
        bit           ez, to, seen;
        int           lat;
        dividend = 32'd5000; divisor = 32'd7; signed_op = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (11) @(posedge clk);   // now in ITER with count 10
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if ({busy, done, div_by_zero} !== 3'b000 || quotient !== '0 || remainder !== '0) begin
            bad++;
            $display("FAIL reset_mid: busy=%b done=%b dbz=%b q=%h r=%h, want all zero",
                     busy, done, div_by_zero, quotient, remainder);
        end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done || busy) seen = 1'b1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL reset_mid_no_done: activity after abort=1, want 0");
        end
        run_op(32'd5000, 32'd7, 1'b0, lat, to);
        ref_div(32'd5000, 32'd7, 1'b0, eq, er, ez);
        total++;
        if (to || lat != W + 2 || quotient !== eq || remainder !== er) begin
            bad++;
            $display("FAIL reset_mid_recover: q=%h r=%h lat=%0d, want q=%h r=%h lat=%0d",
                     quotient, remainder, lat, eq, er, W + 2);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
